// File: rtl/dsp48a1_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : dsp48a1_result_checker
//  Description : Response-side checker for a DSP48A1 under test. Computes the
//                expected P/CARRYOUT of every issued operation with an in-order
//                reference model, delays it LATENCY cycles, compares it with
//                the DUT outputs and keeps pass/fail/skip statistics plus a
//                capture of the first mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp48a1_result_checker #(
    parameter int LATENCY = 3,   // op sample to DUT result, 1..16
    parameter int CNT_W   = 16   // statistics / index counter width
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               op_valid,
    input  logic [17:0]        op_a,
    input  logic [17:0]        op_b,
    input  logic [17:0]        op_d,
    input  logic [47:0]        op_c,
    input  logic [47:0]        op_pcin,
    input  logic [7:0]         op_opmode,
    input  logic [47:0]        dut_p,
    input  logic               dut_carryout,
    output logic               cmp_valid,
    output logic               cmp_ok,
    output logic               err,
    output logic               busy,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [CNT_W-1:0]   skip_cnt,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [47:0]        first_fail_exp,
    output logic [47:0]        first_fail_got
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // Reference model state and operation index
    logic [47:0]        r_model_p;
    logic [CNT_W-1:0]   r_idx;

    // Expectation pipeline, stage LATENCY-1 is the one being compared
    logic [LATENCY-1:0] r_pv;
    logic [LATENCY-1:0] r_ps;
    logic [LATENCY-1:0] r_pco;
    logic [47:0]        r_pp   [LATENCY];
    logic [CNT_W-1:0]   r_pidx [LATENCY];

    // Statistics and compare result
    logic               r_cmp_valid;
    logic               r_cmp_ok;
    logic               r_err;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_skip_cnt;
    logic [CNT_W-1:0]   r_ff_idx;
    logic [47:0]        r_ff_exp;
    logic [47:0]        r_ff_got;

    // Reference model datapath
    logic [47:0]        w_model_p;
    logic [CNT_W-1:0]   w_idx;
    logic [17:0]        w_preadd;
    logic [17:0]        w_bsel;
    logic [35:0]        w_mult;
    logic [47:0]        w_x;
    logic [47:0]        w_z;
    logic               w_cin;
    logic [48:0]        w_res;
    logic               w_busy;
    logic               w_skip;
    logic               w_mat_v;
    logic               w_mat_s;
    logic               w_match;

    // A clear in the same cycle as an op makes that op see a fresh model:
    // P = 0, index 0 and an empty pipeline (so no hazard).
    assign w_model_p = clear ? 48'd0 : r_model_p;
    assign w_idx     = clear ? '0 : r_idx;
    assign w_busy    = |r_pv;
    assign w_cin     = op_opmode[5];

    // Reference model: pre-adder, multiplier, X/Z muxes and post-adder
    always_comb begin
        w_preadd = op_opmode[6] ? (op_d - op_b) : (op_d + op_b);
        w_bsel   = op_opmode[4] ? w_preadd : op_b;
        w_mult   = {18'd0, op_a} * {18'd0, w_bsel};
        case (op_opmode[1:0])
            2'd0:    w_x = 48'd0;
            2'd1:    w_x = {12'd0, w_mult};
            2'd2:    w_x = w_model_p;
            default: w_x = {op_d[11:0], op_a, w_bsel};
        endcase
        case (op_opmode[3:2])
            2'd0:    w_z = 48'd0;
            2'd1:    w_z = op_pcin;
            2'd2:    w_z = w_model_p;
            default: w_z = op_c;
        endcase
        if (op_opmode[7]) begin
            w_res = {1'b0, w_z} - ({1'b0, w_x} + {48'd0, w_cin});
        end else begin
            w_res = {1'b0, w_z} + {1'b0, w_x} + {48'd0, w_cin};
        end
    end

    // Feedback from P while another op is still in flight depends on DUT
    // timing the in-order model does not track, so that result is not judged.
    assign w_skip = op_valid && !clear && w_busy &&
                    ((op_opmode[1:0] == 2'd2) || (op_opmode[3:2] == 2'd2));

    assign w_mat_v = r_pv[LATENCY-1];
    assign w_mat_s = r_ps[LATENCY-1];
    assign w_match = (dut_p == r_pp[LATENCY-1]) && (dut_carryout == r_pco[LATENCY-1]);

    // Model P and op index track every accepted operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_model_p <= 48'd0;
            r_idx     <= '0;
        end else begin
            if (op_valid) begin
                r_model_p <= w_res[47:0];
                r_idx     <= w_idx + C_CNT_ONE;
            end else begin
                r_model_p <= w_model_p;
                r_idx     <= w_idx;
            end
        end
    end

    // Expectation shift register; clear invalidates everything already inside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv  <= '0;
            r_ps  <= '0;
            r_pco <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pp[i]   <= 48'd0;
                r_pidx[i] <= '0;
            end
        end else begin
            r_pv[0]   <= op_valid;
            r_ps[0]   <= w_skip;
            r_pco[0]  <= w_res[48];
            r_pp[0]   <= w_res[47:0];
            r_pidx[0] <= w_idx;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i]   <= clear ? 1'b0 : r_pv[i-1];
                r_ps[i]   <= r_ps[i-1];
                r_pco[i]  <= r_pco[i-1];
                r_pp[i]   <= r_pp[i-1];
                r_pidx[i] <= r_pidx[i-1];
            end
        end
    end

    // Compare the maturing expectation and update statistics / first-fail capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_ok    <= 1'b0;
            r_err       <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_skip_cnt  <= '0;
            r_ff_idx    <= '0;
            r_ff_exp    <= 48'd0;
            r_ff_got    <= 48'd0;
        end else if (clear) begin
            r_cmp_valid <= 1'b0;
            r_cmp_ok    <= 1'b0;
            r_err       <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_skip_cnt  <= '0;
            r_ff_idx    <= '0;
            r_ff_exp    <= 48'd0;
            r_ff_got    <= 48'd0;
        end else begin
            r_cmp_valid <= w_mat_v && !w_mat_s;
            r_cmp_ok    <= w_mat_v && !w_mat_s && w_match;
            if (w_mat_v) begin
                if (w_mat_s) begin
                    if (r_skip_cnt != C_CNT_MAX) begin
                        r_skip_cnt <= r_skip_cnt + C_CNT_ONE;
                    end
                end else if (w_match) begin
                    if (r_pass_cnt != C_CNT_MAX) begin
                        r_pass_cnt <= r_pass_cnt + C_CNT_ONE;
                    end
                end else begin
                    r_err <= 1'b1;
                    if (r_fail_cnt != C_CNT_MAX) begin
                        r_fail_cnt <= r_fail_cnt + C_CNT_ONE;
                    end
                    if (r_fail_cnt == '0) begin
                        r_ff_idx <= r_pidx[LATENCY-1];
                        r_ff_exp <= r_pp[LATENCY-1];
                        r_ff_got <= dut_p;
                    end
                end
            end
        end
    end

    assign cmp_valid      = r_cmp_valid;
    assign cmp_ok         = r_cmp_ok;
    assign err            = r_err;
    assign busy           = w_busy;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign skip_cnt       = r_skip_cnt;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_exp = r_ff_exp;
    assign first_fail_got = r_ff_got;

endmodule
`default_nettype wire

// File: tb/tb_dsp48a1_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp48a1_result_checker
//  Description : Self-checking bench for dsp48a1_result_checker. The bench
//                plays the DSP: it schedules dut_p/dut_carryout LATENCY cycles
//                after each op and queues the cmp_ok it expects.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp48a1_result_checker;

    localparam int LAT   = 3;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic               op_valid;
    logic [17:0]        op_a, op_b, op_d;
    logic [47:0]        op_c, op_pcin;
    logic [7:0]         op_opmode;
    logic [47:0]        dut_p;
    logic               dut_carryout;
    logic               cmp_valid, cmp_ok, err, busy;
    logic [CNT_W-1:0]   pass_cnt, fail_cnt, skip_cnt, first_fail_idx;
    logic [47:0]        first_fail_exp, first_fail_got;

    dsp48a1_result_checker #(.LATENCY(LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .op_valid(op_valid),
        .op_a(op_a), .op_b(op_b), .op_d(op_d), .op_c(op_c), .op_pcin(op_pcin),
        .op_opmode(op_opmode), .dut_p(dut_p), .dut_carryout(dut_carryout),
        .cmp_valid(cmp_valid), .cmp_ok(cmp_ok), .err(err), .busy(busy),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp),
        .first_fail_got(first_fail_got)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  opm;
        logic [17:0] a, b, d;
        logic [47:0] c, pcin;
        logic [47:0] p;
        logic        co;
    } vec_t;

    vec_t        vecs [13];
    bit          exp_q [$];
    logic [47:0] sched_p  [int];
    logic        sched_co [int];
    int          ecnt   = 0;
    int          pulses = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance to the next falling edge, score any compare, drive the DSP result
    task automatic tick();
        bit e;
        @(negedge clk);
        ecnt++;
        if (cmp_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_cmp_valid: got 1 expected 0 at edge %0d", ecnt);
            end else begin
                e = exp_q.pop_front();
                check("cmp_ok", {63'd0, cmp_ok}, {63'd0, e});
            end
        end
        dut_p        = sched_p.exists(ecnt) ? sched_p[ecnt] : 48'd0;
        dut_carryout = sched_co.exists(ecnt) ? sched_co[ecnt] : 1'b0;
    endtask

    task automatic issue(input logic [7:0] opm, input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] d, input logic [47:0] c, input logic [47:0] pcin,
                         input logic [47:0] dp, input logic dco, input bit ok,
                         input bit is_skip, input bit clr);
        tick();
        op_valid  = 1'b1;
        clear     = clr;
        op_opmode = opm;
        op_a = a; op_b = b; op_d = d; op_c = c; op_pcin = pcin;
        if (clr) exp_q.delete();
        sched_p[ecnt + LAT]  = dp;
        sched_co[ecnt + LAT] = dco;
        if (!is_skip) exp_q.push_back(ok);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            op_valid = 1'b0;
            clear    = 1'b0;
        end
    endtask

    task automatic do_clear();
        tick();
        op_valid = 1'b0;
        clear    = 1'b1;
        exp_q.delete();
    endtask

    // Run until every queued expectation has been scored, bounded
    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while ((exp_q.size() != 0 || busy) && n < 64) begin
            idle(1);
            n++;
        end
        idle(1);
        check("drain_timeout", {63'd0, (exp_q.size() != 0)}, 64'd0);
    endtask

    initial begin
        int p0;
        vecs[0]  = '{8'h01, 18'd3,  18'd5,  18'd0,       48'd0,               48'd0,               48'd15,              1'b0};
        vecs[1]  = '{8'h11, 18'd2,  18'd4,  18'd10,      48'd0,               48'd0,               48'd28,              1'b0};
        vecs[2]  = '{8'h8D, 18'd2,  18'd3,  18'd0,       48'd100,             48'd0,               48'd94,              1'b0};
        vecs[3]  = '{8'h8D, 18'd10, 18'd10, 18'd0,       48'd6,               48'd0,               48'hFFFF_FFFF_FFA2,  1'b1};
        vecs[4]  = '{8'h0C, 18'd0,  18'd0,  18'd0,       48'h1234_5678_9ABC,  48'd0,               48'h1234_5678_9ABC,  1'b0};
        vecs[5]  = '{8'h09, 18'd1,  18'd1,  18'd0,       48'd0,               48'd0,               48'h1234_5678_9ABD,  1'b0};
        vecs[6]  = '{8'h04, 18'd0,  18'd0,  18'd0,       48'd0,               48'hFFFF_FFFF_FFFF,  48'hFFFF_FFFF_FFFF,  1'b0};
        vecs[7]  = '{8'h24, 18'd0,  18'd0,  18'd0,       48'd0,               48'hFFFF_FFFF_FFFF,  48'd0,               1'b1};
        vecs[8]  = '{8'h03, 18'd1,  18'd2,  18'h3_0ABC, 48'd0,               48'd0,               48'hABC0_0004_0002,  1'b0};
        vecs[9]  = '{8'h51, 18'd1,  18'd7,  18'd5,       48'd0,               48'd0,               48'h3_FFFE,          1'b0};
        vecs[10] = '{8'h88, 18'd0,  18'd0,  18'd0,       48'd0,               48'd0,               48'h3_FFFE,          1'b0};
        vecs[11] = '{8'hA2, 18'd0,  18'd0,  18'd0,       48'd0,               48'd0,               48'hFFFF_FFFC_0001,  1'b1};
        vecs[12] = '{8'h0B, 18'd0,  18'd1,  18'd0,       48'd0,               48'd0,               48'hFFFF_FFFC_0002,  1'b0};

        rst_n = 1'b0; clear = 1'b0; op_valid = 1'b0;
        op_a = '0; op_b = '0; op_d = '0; op_c = '0; op_pcin = '0; op_opmode = '0;
        dut_p = '0; dut_carryout = 1'b0;
        idle(3);
        check("rst_cmp_valid", {63'd0, cmp_valid}, 64'd0);
        check("rst_err_busy", {62'd0, err, busy}, 64'd0);
        check("rst_counters", {16'd0, pass_cnt, fail_cnt, skip_cnt}, 64'd0);
        check("rst_capture", {first_fail_idx, first_fail_exp}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Table of isolated ops; model P carries from one entry to the next
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].opm, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, vecs[i].pcin,
                  vecs[i].p, vecs[i].co, 1'b1, 1'b0, 1'b0);
            idle(LAT + 1);
        end
        drain();
        check("table_pass_cnt", {48'd0, pass_cnt}, 64'd13);
        check("table_fail_err", {47'd0, err, fail_cnt}, 64'd0);

        // First mismatch capture, then a second mismatch must not overwrite it
        do_clear();
        issue(8'h01, 18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 48'd16, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        check("mm_fail_err", {47'd0, err, fail_cnt}, {47'd0, 1'b1, 16'd1});
        check("mm_idx", {48'd0, first_fail_idx}, 64'd0);
        check("mm_exp", {16'd0, first_fail_exp}, 64'd15);
        check("mm_got", {16'd0, first_fail_got}, 64'd16);
        issue(8'h01, 18'd2, 18'd2, 18'd0, 48'd0, 48'd0, 48'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        check("mm2_fail_cnt", {48'd0, fail_cnt}, 64'd2);
        check("mm2_capture", {first_fail_idx, first_fail_exp[47:0]}, 64'd15);
        check("mm2_got", {16'd0, first_fail_got}, 64'd16);

        // Back-to-back, second op reads P while busy -> skipped
        do_clear();
        p0 = pulses;
        issue(8'h01, 18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 48'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(8'h09, 18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 48'd16, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        check("hz_skip_pass", {32'd0, skip_cnt, pass_cnt}, {32'd0, 16'd1, 16'd1});
        check("hz_pulses", 64'(pulses - p0), 64'd1);

        // Asynchronous reset with two ops in flight
        issue(8'h01, 18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 48'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(8'h01, 18'd2, 18'd1, 18'd0, 48'd0, 48'd0, 48'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", {60'd0, cmp_valid, cmp_ok, err, busy}, 64'd0);
        check("arst_counters", {16'd0, pass_cnt, fail_cnt, skip_cnt}, 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        p0 = pulses;
        idle(LAT + 3);
        check("arst_no_pulse", 64'(pulses - p0), 64'd0);

        // Same with a synchronous clear
        issue(8'h01, 18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 48'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(8'h01, 18'd2, 18'd1, 18'd0, 48'd0, 48'd0, 48'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        do_clear();
        p0 = pulses;
        idle(LAT + 3);
        check("clr_no_pulse", 64'(pulses - p0), 64'd0);
        check("clr_state", {15'd0, busy, pass_cnt, fail_cnt, skip_cnt}, 64'd0);

        // Op accepted in the clear cycle, accumulating onto a flushed P of 0
        issue(8'h01, 18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 48'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(8'h09, 18'd2, 18'd2, 18'd0, 48'd0, 48'd0, 48'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();
        check("clr_op_pass", {32'd0, pass_cnt, fail_cnt}, {32'd0, 16'd1, 16'd0});

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
